// File: rtl/rah_tx_packer_if.sv
// ---------------------------------------------------------------------------
// rah_tx_packer_if
//   Bundles the packet-side and word-side signals of the RAH TX packer.
//
//   Signals
//     in_valid  : in_data holds a RAH packet
//     in_ready  : packer accepts in_data this cycle
//     in_data   : RAH packet, DATA_WIDTH bits
//     flush     : one-cycle pulse, emit any partial word zero-padded
//     out_valid : out_data holds a packed MIPI word
//     out_ready : MIPI TX timing takes the word this cycle
//     out_data  : packed word, MIPI_WIDTH bits
//
//   Modports
//     master : packet producer / word consumer (encoder side + MIPI TX)
//     slave  : the packer itself
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid && ready are both high. The packer derives in_ready and
//   out_valid from registered state only, so ready never depends on valid of
//   the same channel and there is no out_ready -> in_ready path. While
//   in_valid is high without in_ready, the producer may change in_data; the
//   packer only samples it on the transfer edge.
// ---------------------------------------------------------------------------
interface rah_tx_packer_if #(
    parameter int DATA_WIDTH = 48,
    parameter int MIPI_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [MIPI_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/rah_tx_packer.sv
// ---------------------------------------------------------------------------
// rah_tx_packer
//   Gearbox from DATA_WIDTH-bit RAH packets to MIPI_WIDTH-bit MIPI TX words.
//   Packets are packed little-endian: the first packet lands in the LSBs of
//   the first word. A flush pulse emits a trailing partial word with its
//   unused upper lanes zero. Transmit-side inverse of the RX data aligner.
//
//   Ports
//     clk        : single clock
//     reset_n    : asynchronous active-low reset
//     bus        : rah_tx_packer_if.slave (packet in, word out, flush)
//     flush_busy : a flush is pending and not yet complete
//     word_count : words emitted since reset, wraps 0xFFFF -> 0
//
//   The accumulator holds up to 2*ML lanes. Lanes at or above fill are
//   always zero, so a new packet is ORed in at the post-pop fill position and
//   a partial flush word needs no extra masking.
// ---------------------------------------------------------------------------
module rah_tx_packer #(
    parameter int DATA_WIDTH = 48,
    parameter int MIPI_WIDTH = 64,
    parameter int LANE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    rah_tx_packer_if.slave bus,
    output logic        flush_busy,
    output logic [15:0] word_count
);

    localparam int DL    = DATA_WIDTH / LANE_WIDTH;
    localparam int ML    = MIPI_WIDTH / LANE_WIDTH;
    localparam int LANES = 2 * ML;
    localparam int ACC   = 2 * MIPI_WIDTH;
    localparam int FW    = $clog2(LANES + 1);
    localparam int SHW   = $clog2(ACC);

    localparam logic [FW-1:0] ML_F      = FW'(ML);
    localparam logic [FW-1:0] DL_F      = FW'(DL);
    // Highest fill at which a whole packet still fits without a pop.
    localparam logic [FW-1:0] READY_MAX = FW'(LANES - DL);

    // Registered state
    logic [ACC-1:0] acc_q;
    logic [FW-1:0]  fill_q;
    logic           flush_pend_q;
    logic [15:0]    word_count_q;

    // Next-state / intermediate
    logic [ACC-1:0] acc_pp;
    logic [ACC-1:0] acc_d;
    logic [ACC-1:0] in_ext;
    logic [FW-1:0]  fill_pp;
    logic [FW-1:0]  fill_d;
    logic [SHW-1:0] lane_shift;
    logic           flush_pend_d;
    logic           in_ready_int;
    logic           out_valid_int;
    logic           pop;
    logic           accept;

    // Handshake terms come from state only.
    assign in_ready_int  = !flush_pend_q && (fill_q <= READY_MAX);
    assign out_valid_int = (fill_q >= ML_F) || (flush_pend_q && (fill_q != '0));

    assign pop    = out_valid_int && bus.out_ready;
    assign accept = bus.in_valid && in_ready_int;

    // Outputs are forced quiet while reset is asserted; in_ready would
    // otherwise read 1 from the cleared state.
    assign bus.in_ready  = reset_n && in_ready_int;
    assign bus.out_valid = reset_n && out_valid_int;
    assign bus.out_data  = reset_n ? acc_q[MIPI_WIDTH-1:0] : '0;
    assign flush_busy    = reset_n && flush_pend_q;
    assign word_count    = reset_n ? word_count_q : '0;

    // Pop first, then append at the post-pop fill position.
    always_comb begin
        acc_pp  = acc_q;
        fill_pp = fill_q;
        if (pop) begin
            // Shifting brings zeros into the vacated upper lanes.
            acc_pp  = acc_q >> MIPI_WIDTH;
            fill_pp = (fill_q >= ML_F) ? (fill_q - ML_F) : '0;
        end

        // Only meaningful when accept is high, which implies fill_pp <= READY_MAX,
        // so the product never exceeds ACC - DATA_WIDTH.
        lane_shift = SHW'(fill_pp) * SHW'(LANE_WIDTH);
        in_ext     = ACC'(bus.in_data) << lane_shift;

        acc_d  = acc_pp;
        fill_d = fill_pp;
        if (accept) begin
            acc_d  = acc_pp | in_ext;
            fill_d = fill_pp + DL_F;
        end

        // A flush arriving while one is pending is ignored. A pending flush
        // completes on the edge where the post-pop fill is zero; no packet
        // can be accepted while it is pending, so fill only drains.
        if (flush_pend_q) begin
            flush_pend_d = (fill_pp != '0);
        end else begin
            flush_pend_d = bus.flush;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
            if (pop) begin
                word_count_q <= word_count_q + 16'd1;
            end
        end
    end

endmodule
